// File: rtl/assoc_trainer_pkg.sv
// Shared constants for the associate trainer: FSM state codes, phase type and activation levels.
`timescale 1ns/1ps
package assoc_trainer_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FWD  = 3'd1;
  localparam logic [2:0] S_RES  = 3'd2;
  localparam logic [2:0] S_BWD  = 3'd3;
  localparam logic [2:0] S_FBK  = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd5;

  typedef enum logic {
    PH_TRAIN = 1'b0,
    PH_EVAL  = 1'b1
  } phase_t;

  localparam logic [15:0] ACT_LOW  = 16'h0000;
  localparam logic [15:0] ACT_HIGH = 16'h00ff;

endpackage

// File: rtl/assoc_trainer_mem.sv
// Sample store: one write port, one combinational read port, contents survive reset.
`timescale 1ns/1ps
module assoc_trainer_mem #(
  parameter int AW    = 16,
  parameter int RESW  = 16,
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [AW-1:0]   warg,
  input  logic [RESW-1:0] wtgt,
  input  logic [IW-1:0]   raddr,
  output logic [AW-1:0]   rarg,
  output logic [RESW-1:0] rtgt
);

  logic [AW-1:0]   arg_q [DEPTH];
  logic [RESW-1:0] tgt_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      arg_q[waddr] <= warg;
      tgt_q[waddr] <= wtgt;
    end
  end

  assign rarg = arg_q[raddr];
  assign rtgt = tgt_q[raddr];

endmodule

// File: rtl/assoc_trainer.sv
// Trains an associate unit over the stored samples for EPOCHS epochs, then runs one evaluation pass.
// Optional ASSOC_TRAINER_EARLY_STOP_EN: leave training after the first epoch with no sample error.
`timescale 1ns/1ps
module assoc_trainer import assoc_trainer_pkg::*; #(
  parameter int ARGN   = 2,
  parameter int ARGW   = 8,
  parameter int RESW   = 16,
  parameter int ERRW   = 16,
  parameter int FBKN   = ARGN,
  parameter int FBKW   = 16,
  parameter int DEPTH  = 4,
  parameter int EPOCHS = 25,
  parameter logic [RESW-1:0] HIGH = RESW'(ACT_HIGH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   miss,
  output logic [$clog2(EPOCHS+1)-1:0]  epoch,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [$clog2(DEPTH)-1:0]     ld_addr,
  input  logic [ARGN*ARGW-1:0]         ld_arg,
  input  logic [RESW-1:0]              ld_tgt,
  output logic                         en,
  output logic                         arg_valid,
  input  logic                         arg_ready,
  output logic [ARGN*ARGW-1:0]         arg_data,
  input  logic                         res_valid,
  output logic                         res_ready,
  input  logic [RESW-1:0]              res_data,
  output logic                         err_valid,
  input  logic                         err_ready,
  output logic [ERRW-1:0]              err_data,
  input  logic                         fbk_valid,
  output logic                         fbk_ready,
  input  logic [FBKN*FBKW-1:0]         fbk_data
);

  localparam int IW = $clog2(DEPTH);
  localparam int MW = $clog2(DEPTH+1);
  localparam int EW = $clog2(EPOCHS+1);
  localparam int AW = ARGN*ARGW;

  function automatic logic [RESW-1:0] activate(input logic [RESW-1:0] r);
    return ($signed(r) < 0) ? RESW'(ACT_LOW) : HIGH;
  endfunction

  function automatic logic [ERRW-1:0] error_fit(input logic signed [RESW-1:0] t,
                                                input logic signed [RESW-1:0] a);
    logic signed [RESW-1:0] d;
    d = t - a;
    return ERRW'(d);
  endfunction

  logic [2:0]      state_q;
  logic [IW-1:0]   idx_q;
  logic [EW-1:0]   epoch_q;
  logic [MW-1:0]   miss_q;
  phase_t          phase_q;
  logic            en_q;
  logic            done_q;
  logic [ERRW-1:0] err_q;
  logic [AW-1:0]   arg_rd;
  logic [RESW-1:0] tgt_rd;
  logic [ERRW-1:0] err_n;
  logic [EW-1:0]   epoch_inc;
  logic            last_idx;
  logic            stop_train;
  logic            unused_fbk;

  assoc_trainer_mem #(.AW(AW), .RESW(RESW), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (ld_valid && ld_ready),
    .waddr (ld_addr),
    .warg  (ld_arg),
    .wtgt  (ld_tgt),
    .raddr (idx_q),
    .rarg  (arg_rd),
    .rtgt  (tgt_rd)
  );

  assign err_n     = error_fit(tgt_rd, activate(res_data));
  assign epoch_inc = epoch_q + EW'(1);
  assign last_idx  = (idx_q == IW'(DEPTH-1));
  assign unused_fbk = ^fbk_data;

`ifdef ASSOC_TRAINER_EARLY_STOP_EN
  logic ep_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ep_err_q <= 1'b0;
    end else if (state_q == S_IDLE || (state_q == S_NEXT && last_idx)) begin
      ep_err_q <= 1'b0;
    end else if (state_q == S_RES && res_valid && phase_q == PH_TRAIN && err_n != '0) begin
      ep_err_q <= 1'b1;
    end
  end

  assign stop_train = (epoch_inc == EW'(EPOCHS)) || !ep_err_q;
`else
  assign stop_train = (epoch_inc == EW'(EPOCHS));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      epoch_q <= '0;
      miss_q  <= '0;
      phase_q <= PH_TRAIN;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_FWD;
          idx_q   <= '0;
          epoch_q <= '0;
          phase_q <= PH_TRAIN;
          en_q    <= 1'b1;
        end
        S_FWD: if (arg_ready) state_q <= S_RES;
        S_RES: if (res_valid) begin
          err_q <= err_n;
          if (phase_q == PH_EVAL) begin
            if (err_n != '0) miss_q <= miss_q + MW'(1);
            state_q <= S_NEXT;
          end else begin
            state_q <= S_BWD;
          end
        end
        S_BWD: if (err_ready) state_q <= S_FBK;
        S_FBK: if (fbk_valid) state_q <= S_NEXT;
        S_NEXT: begin
          if (!last_idx) begin
            idx_q   <= idx_q + IW'(1);
            state_q <= S_FWD;
          end else if (phase_q == PH_TRAIN) begin
            epoch_q <= epoch_inc;
            idx_q   <= '0;
            state_q <= S_FWD;
            if (stop_train) begin
              phase_q <= PH_EVAL;
              en_q    <= 1'b0;
              miss_q  <= '0;
            end
          end else begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign ld_ready  = (state_q == S_IDLE);
  assign arg_valid = (state_q == S_FWD);
  assign res_ready = (state_q == S_RES);
  assign err_valid = (state_q == S_BWD);
  assign fbk_ready = (state_q == S_FBK);
  assign arg_data  = arg_rd;
  assign err_data  = err_q;
  assign en        = en_q;
  assign done      = done_q;
  assign miss      = miss_q;
  assign epoch     = epoch_q;

endmodule
